mod_reduce_scheduler: RTL and testbench
=======================================

# mod_reduce_scheduler

Round-robin scheduler that shares one sequential modulo-reduction engine among NUM_REQ requesters. Each requester presents a (number, m) pair with a valid/ready handshake; the scheduler grants one request at a time, runs the engine, and returns number mod m tagged with the requester index. It sits between the client datapaths and the reduction arithmetic, replacing per-client combinational reducers with one time-shared unit.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width in bits
- ID_W, $clog2(NUM_REQ), width of requester tag
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high
- req_number  in  NUM_REQ*WIDTH  dividends, requester i at bits [i*WIDTH +: WIDTH]
- req_m  in  NUM_REQ*WIDTH  moduli, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of requester that issued the result
- rsp_result  out  WIDTH  number mod m
- rsp_err  out  1  m was zero (only with ZERO_CHECK_EN)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: req_ready is combinational, one-hot to the round-robin winner among asserted req_valid; zero when no request. Handshake (req_valid[i] & req_ready[i]) latches number, m, id; go to RUN; the round-robin pointer becomes i.
- Arbitration: search starts at pointer+1 modulo NUM_REQ; pointer resets to NUM_REQ-1, so requester 0 wins first after reset.
- RUN: restoring shift-subtract, one dividend bit per cycle, MSB first: r = {r, bit}; if r >= m then r -= m. Remainder register is WIDTH+1 bits to hold the shifted value; bit counter counts WIDTH cycles, then go to DONE.
- DONE: rsp_valid high; rsp_id/rsp_result/rsp_err stable until rsp_valid & rsp_ready, then go to IDLE. No grant is issued outside IDLE.
- Arithmetic: unsigned; result always < m for m != 0; number < m gives result = number.
- Requesters must hold req_number/req_m stable while req_valid is high and not granted; values are sampled only on the handshake cycle.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_err 0, state IDLE, pointer NUM_REQ-1.
- Handshake at edge T; RUN occupies cycles T+1..T+WIDTH; rsp_valid high from the cycle after T+WIDTH, so latency is WIDTH+1 cycles from grant to rsp_valid.
- Response accepted at edge U; the earliest next grant is the cycle after U. Throughput is one result per WIDTH+2 cycles with rsp_ready held high.
- rst in any state (including mid-RUN or DONE with rsp_valid high) aborts the operation, drops the result, and restores reset values on the next edge.
- A requester that deasserts req_valid before being granted is simply skipped; there is no penalty.

## Configuration
- MOD_SCHED_ZERO_CHECK_EN defined: on handshake with m == 0, skip RUN and go straight to DONE. rsp_valid is high the cycle after the grant, with rsp_err = 1 and rsp_result = number.
- Undefined: rsp_err is tied 0. m == 0 runs the full WIDTH cycles; the algorithm naturally yields rsp_result = number.

## Structure
- Shared package mod_reduce_pkg: state enum (IDLE/RUN/DONE), default WIDTH constant, and a round-robin next-grant function.
- Sub-module mod_reduce_engine: start/busy/done interface, operand registers, WIDTH+1-bit remainder and bit counter. The scheduler holds the arbiter, FSM and response registers.

## Test plan
- Requester 0 sends 10 mod 3, others idle, rsp_ready=1 -> req_ready=4'b0001 for one cycle; rsp_valid 33 cycles later with rsp_result=1, rsp_id=0.
- All four requesters valid continuously, each with m=7 and number=100+i -> grants in order 0,1,2,3,0; results 2,3,4,5 with matching rsp_id.
- rsp_ready low for 10 cycles in DONE -> rsp_valid, rsp_result and rsp_id stay constant, req_ready stays 0; completes on the first cycle rsp_ready=1.
- Edge operands: 0xFFFFFFFF mod 0xFFFFFFFF -> 0; 5 mod 9 -> 5; 0 mod 1 -> 0; 0xFFFFFFFF mod 2 -> 1.
- m=0, number=42 -> with the macro: rsp_valid the next cycle, rsp_err=1, result 42; without the macro: after 33 cycles, rsp_err=0, result 42.
- rst pulsed at RUN cycle 10 -> rsp_valid never rises for that request; all outputs return to reset values; the next grant goes to requester 0.

Source files
------------

// File: rtl/mod_reduce_pkg.sv
// Shared types and helpers for the time-shared modulo-reduction scheduler.
package mod_reduce_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int MAX_REQ   = 8;

    // Round-robin winner: first asserted valid starting at ptr+1, wrapping at n.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic int unsigned rr_winner(input logic [MAX_REQ-1:0] valid,
                                              input int unsigned ptr,
                                              input int unsigned n);
        int unsigned idx;
        int unsigned win;
        logic        found;
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (!found && k <= n && idx < MAX_REQ && valid[idx[2:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mod_reduce_engine.sv
// Sequential restoring shift-subtract reducer: one dividend bit per cycle, MSB first.
module mod_reduce_engine
    import mod_reduce_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] number,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] num_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   rem_nxt;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    // Remainder stays below m, so the shifted value always fits in WIDTH+1 bits.
    always_comb begin
        shifted = (rem_q << 1) | (WIDTH+1)'(num_q[WIDTH-1]);
        rem_nxt = (shifted >= {1'b0, m_q}) ? shifted - {1'b0, m_q} : shifted;
    end

    assign busy   = busy_q;
    assign done   = busy_q && (cnt_q == CW'(1));
    assign result = rem_nxt[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q  <= '0;
            m_q    <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            num_q  <= number;
            m_q    <= m;
            rem_q  <= '0;
            cnt_q  <= CW'(WIDTH);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            num_q <= num_q << 1;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mod_reduce_scheduler.sv
// Round-robin front end sharing one mod_reduce_engine among NUM_REQ requesters.
// Optional MOD_SCHED_ZERO_CHECK_EN: m == 0 short-circuits to DONE with rsp_err set.
module mod_reduce_scheduler
    import mod_reduce_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_number,
    input  logic [NUM_REQ*WIDTH-1:0] req_m,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_err
);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    win_id;
    logic [MAX_REQ-1:0] vext;
    logic [WIDTH-1:0]   win_num;
    logic [WIDTH-1:0]   win_m;
    logic               hs;
    logic               m_zero;
    logic               eng_start;
    logic               eng_busy;
    logic               eng_done;
    logic [WIDTH-1:0]   eng_result;

    always_comb begin
        vext               = '0;
        vext[NUM_REQ-1:0]  = req_valid;
        win_id             = ID_W'(rr_winner(vext, 32'(ptr_q), NUM_REQ));
    end

    assign win_num = req_number[win_id*WIDTH +: WIDTH];
    assign win_m   = req_m[win_id*WIDTH +: WIDTH];

`ifdef MOD_SCHED_ZERO_CHECK_EN
    assign m_zero = (win_m == '0);
`else
    assign m_zero = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        hs        = 1'b0;
        eng_start = 1'b0;
        case (state_q)
            IDLE: begin
                // Grant is suppressed during rst so no request is latched while resetting.
                if (!rst && |req_valid) begin
                    req_ready = NUM_REQ'(1) << win_id;
                    hs        = 1'b1;
                    eng_start = !m_zero;
                    state_d   = m_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (eng_done)       state_d = DONE;
                else if (!eng_busy) state_d = IDLE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                ptr_q   <= win_id;
                rsp_id  <= win_id;
                rsp_err <= m_zero;
                if (m_zero) rsp_result <= win_num;
            end else if (eng_done) begin
                rsp_result <= eng_result;
            end
        end
    end

    assign rsp_valid = (state_q == DONE);

    mod_reduce_engine #(.WIDTH(WIDTH)) u_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .number (win_num),
        .m      (win_m),
        .busy   (eng_busy),
        .done   (eng_done),
        .result (eng_result)
    );

endmodule

// File: tb/tb_mod_reduce_scheduler.sv
// Directed + randomized bench for mod_reduce_scheduler against an arithmetic reference model.
module tb_mod_reduce_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int ID_W    = $clog2(NUM_REQ);
`ifdef MOD_SCHED_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_number;
    logic [NUM_REQ*WIDTH-1:0] req_m;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_result;
    logic                     rsp_err;

    logic [WIDTH-1:0] num_a [NUM_REQ];
    logic [WIDTH-1:0] m_a   [NUM_REQ];
    int               ptr_m;
    int               n_chk  = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_number = '0;
        req_m      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_number[i*WIDTH +: WIDTH] = num_a[i];
            req_m[i*WIDTH +: WIDTH]      = m_a[i];
        end
    end

    mod_reduce_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_number (req_number),
        .req_m      (req_m),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_mod(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] m);
        return (m == 0) ? n : n % m;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (p + k) % NUM_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic rand_ops(input int i);
        num_a[i] = $urandom;
        case ($urandom_range(0, 3))
            0:       m_a[i] = $urandom_range(1, 16);
            1:       m_a[i] = $urandom;
            2:       m_a[i] = $urandom >> $urandom_range(0, 31);
            default: m_a[i] = $urandom_range(1, 1000);
        endcase
    endtask

    // Called at a negedge while the DUT is idle; returns at a negedge back in IDLE.
    task automatic serve(input string tag, input int hold, input bit drop);
        int               id, lat, exp_lat;
        logic [WIDTH-1:0] en, em, er;
        bit               quiet, stable;
        #1;
        id = rr_pick(req_valid, ptr_m);
        if (id < 0) begin
            check({tag, " no grant"}, req_ready, 0);
            return;
        end
        check({tag, " grant"}, req_ready, NUM_REQ'(1) << id);
        en      = num_a[id];
        em      = m_a[id];
        er      = ref_mod(en, em);
        exp_lat = (ZC && em == 0) ? 1 : WIDTH + 1;
        ptr_m   = id;
        rsp_ready = (hold == 0);
        @(negedge clk);
        if (drop) req_valid[id] = 1'b0;
        lat   = 1;
        quiet = 1'b1;
        while (!rsp_valid && lat < 3 * WIDTH) begin
            if (req_ready != 0) quiet = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({tag, " no grant while busy"}, quiet, 1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rsp_id"}, rsp_id, id);
        check({tag, " rsp_result"}, rsp_result, er);
        check({tag, " rsp_err"}, rsp_err, (ZC && em == 0));
        if (hold > 0) begin
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_id !== ID_W'(id) || req_ready !== '0)
                    stable = 1'b0;
            end
            check({tag, " hold stable"}, stable, 1);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check({tag, " rsp accepted"}, rsp_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        ptr_m = NUM_REQ - 1;
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        ptr_m     = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            num_a[i] = '0;
            m_a[i]   = 1;
        end
        repeat (3) @(negedge clk);

        // reset state, with a request pending to confirm no grant under reset
        req_valid = 4'b0010;
        #1;
        check("reset req_ready", req_ready, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_id", rsp_id, 0);
        check("reset rsp_result", rsp_result, 0);
        check("reset rsp_err", rsp_err, 0);
        req_valid = '0;
        rst       = 1'b0;
        @(negedge clk);

        // single requester: 10 mod 3
        num_a[0] = 10; m_a[0] = 3; req_valid[0] = 1'b1;
        serve("t1", 0, 1);

        // all requesters continuously valid: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            num_a[i] = 100 + i;
            m_a[i]   = 7;
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) serve("rr", 0, 0);
        req_valid = '0;

        // consumer stalls 10 cycles in DONE
        num_a[3] = 1000; m_a[3] = 13; req_valid[3] = 1'b1;
        serve("stall", 10, 1);

        // edge operands
        begin
            logic [WIDTH-1:0] en [4];
            logic [WIDTH-1:0] em [4];
            en = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'hFFFF_FFFF};
            em = '{32'hFFFF_FFFF, 32'd9, 32'd1, 32'd2};
            for (int k = 0; k < 4; k++) begin
                num_a[1] = en[k]; m_a[1] = em[k]; req_valid[1] = 1'b1;
                serve("edge", 0, 1);
            end
        end

        // zero modulus
        num_a[2] = 42; m_a[2] = 0; req_valid[2] = 1'b1;
        serve("mzero", 0, 1);

        // reset in the middle of RUN drops the operation
        num_a[2] = 12345; m_a[2] = 17; req_valid = 4'b0100;
        #1;
        check("abort grant", req_ready, 4'b0100);
        @(negedge clk);
        num_a[0] = 77; m_a[0] = 10; req_valid[0] = 1'b1;
        repeat (9) @(negedge clk);
        check("abort running", rsp_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort req_ready", req_ready, 0);
        check("abort rsp_valid", rsp_valid, 0);
        check("abort rsp_id", rsp_id, 0);
        check("abort rsp_result", rsp_result, 0);
        check("abort rsp_err", rsp_err, 0);
        rst   = 1'b0;
        ptr_m = NUM_REQ - 1;
        serve("post-abort", 0, 1);
        serve("post-abort", 0, 1);

        // randomized traffic with holds, drops and skipped requesters
        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    rand_ops(i);
                    req_valid[i] = 1'b1;
                end
            if ($urandom_range(0, 5) == 0) req_valid[$urandom_range(0, NUM_REQ-1)] = 1'b0;
            if (req_valid == '0) begin
                rand_ops(0);
                req_valid[0] = 1'b1;
            end
            serve("rand", $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            if (req_valid[ptr_m]) rand_ops(ptr_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
